// File: rtl/wvlt_lift53_if.sv
// Sample-pair input and coefficient-pair output bundle of the 5/3 lifting stage.
interface wvlt_lift53_if #(
    parameter int unsigned pW_DAT = 16,
    parameter int unsigned pW_CNT = 10
);
    logic                     iclk_ena;
    logic                     iena;
    logic signed [pW_DAT-1:0] idat_l;
    logic signed [pW_DAT-1:0] idat_h;
    logic                     oclk_ena;
    logic                     oena;
    logic signed [pW_DAT:0]   oapr;
    logic signed [pW_DAT:0]   odet;
    logic [pW_CNT-1:0]        oidx;
    logic                     olast;

    modport slave (
        input  iclk_ena, iena, idat_l, idat_h,
        output oclk_ena, oena, oapr, odet, oidx, olast
    );

    modport master (
        output iclk_ena, iena, idat_l, idat_h,
        input  oclk_ena, oena, oapr, odet, oidx, olast
    );
endinterface

// File: rtl/wvlt_lift53.sv
// Forward LeGall 5/3 integer lifting stage: one (approximation, detail) pair per
// accepted (even, odd) sample pair, symmetric extension at both frame edges.
module wvlt_lift53 #(
    parameter int unsigned pW_DAT = 16,
    parameter int unsigned pW_CNT = 10
) (
    input logic         iclk,
    input logic         irst_n,
    wvlt_lift53_if.slave lift_io
);
    localparam int unsigned WS = pW_DAT + 3;
    localparam int unsigned W1 = pW_DAT + 1;
    localparam logic signed [WS-1:0] Two = WS'(2);

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    function automatic logic signed [WS-1:0] sx_s(input logic signed [pW_DAT-1:0] v);
        return {{3{v[pW_DAT-1]}}, v};
    endfunction

    function automatic logic signed [WS-1:0] sx_c(input logic signed [pW_DAT:0] v);
        return {{2{v[pW_DAT]}}, v};
    endfunction

    state_e                   state_q, state_d;
    logic signed [pW_DAT-1:0] pl_q, pl_d, ph_q, ph_d;
    logic [pW_CNT-1:0]        cnt_q, cnt_d;
    logic                     arm_q, arm_d;
    logic                     issue, issue_first, issue_last;
    logic signed [pW_DAT-1:0] nxt_l;
    logic                     acc;

    // Stage 1: detail of the issued pair plus its left-neighbour detail.
    logic                     s1_vld_q, s1_last_q;
    logic [pW_CNT-1:0]        s1_idx_q;
    logic signed [pW_DAT-1:0] s1_l_q;
    logic signed [pW_DAT:0]   s1_d_q, s1_dp_q;
    logic signed [pW_DAT:0]   d_new, a_new;

    // Stage 2: output registers.
    logic                     oclk_q, oena_q, oena_d, last_q;
    logic signed [pW_DAT:0]   apr_q, det_q;
    logic [pW_CNT-1:0]        idx_q;

    assign acc = lift_io.iclk_ena && lift_io.iena;

    always_comb begin
        state_d     = state_q;
        pl_d        = pl_q;
        ph_d        = ph_q;
        cnt_d       = cnt_q;
        arm_d       = arm_q;
        issue       = 1'b0;
        issue_first = 1'b0;
        issue_last  = 1'b0;
        nxt_l       = lift_io.idat_l;
        // A frame may only start after iena has been seen low since reset or the last frame.
        if (!lift_io.iena) arm_d = 1'b1;
        case (state_q)
            StIdle: begin
                if (acc && arm_q) begin
                    pl_d    = lift_io.idat_l;
                    ph_d    = lift_io.idat_h;
                    cnt_d   = '0;
                    arm_d   = 1'b0;
                    state_d = StPrime;
                end
            end
            StPrime, StRun: begin
                issue_first = (state_q == StPrime);
                if (!lift_io.iena) begin
                    issue      = 1'b1;
                    issue_last = 1'b1;
                    nxt_l      = pl_q;
                    state_d    = StIdle;
                end else if (lift_io.iclk_ena) begin
                    issue   = 1'b1;
                    pl_d    = lift_io.idat_l;
                    ph_d    = lift_io.idat_h;
                    cnt_d   = cnt_q + pW_CNT'(1);
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign d_new = W1'(sx_s(ph_q) - ((sx_s(pl_q) + sx_s(nxt_l)) >>> 1));
    assign a_new = W1'(sx_s(s1_l_q) + ((sx_c(s1_dp_q) + sx_c(s1_d_q) + Two) >>> 2));

    always_comb begin
        oena_d = oena_q;
        if (s1_vld_q) oena_d = 1'b1;
        else if (oclk_q && last_q) oena_d = 1'b0;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= StIdle;
            pl_q    <= '0;
            ph_q    <= '0;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pl_q    <= pl_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            arm_q   <= arm_d;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_idx_q  <= '0;
            s1_l_q    <= '0;
            s1_d_q    <= '0;
            s1_dp_q   <= '0;
        end else begin
            s1_vld_q <= issue;
            if (issue) begin
                s1_last_q <= issue_last;
                s1_idx_q  <= cnt_q;
                s1_l_q    <= pl_q;
                s1_d_q    <= d_new;
                // s1_d_q still holds d[n-1]; pair 0 mirrors its own detail.
                s1_dp_q   <= issue_first ? d_new : s1_d_q;
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            oclk_q <= 1'b0;
            oena_q <= 1'b0;
            last_q <= 1'b0;
            apr_q  <= '0;
            det_q  <= '0;
            idx_q  <= '0;
        end else begin
            oclk_q <= s1_vld_q;
            oena_q <= oena_d;
            if (s1_vld_q) begin
                apr_q  <= a_new;
                det_q  <= s1_d_q;
                idx_q  <= s1_idx_q;
                last_q <= s1_last_q;
            end
        end
    end

    assign lift_io.oclk_ena = oclk_q;
    assign lift_io.oena     = oena_q;
    assign lift_io.oapr     = oclk_q ? apr_q : '0;
    assign lift_io.odet     = oclk_q ? det_q : '0;
    assign lift_io.oidx     = idx_q;
    assign lift_io.olast    = last_q;
endmodule

// File: tb/tb_wvlt_lift53.sv
// Directed bench for wvlt_lift53 at pW_DAT=8, pW_CNT=3 with hand-computed coefficients.
module tb_wvlt_lift53;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    typedef struct {
        logic signed [31:0] a;
        logic signed [31:0] d;
        logic signed [31:0] idx;
        logic               last;
        logic               ena;
        int                 at;
    } pulse_t;

    pulse_t q[$];
    pulse_t mon;

    wvlt_lift53_if #(.pW_DAT(8), .pW_CNT(3)) bus ();

    wvlt_lift53 #(.pW_DAT(8), .pW_CNT(3)) dut (
        .iclk   (clk),
        .irst_n (rst_n),
        .lift_io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.oclk_ena === 1'b1) begin
            mon.a    = bus.oapr;
            mon.d    = bus.odet;
            mon.idx  = {29'd0, bus.oidx};
            mon.last = bus.olast;
            mon.ena  = bus.oena;
            mon.at   = cyc;
            q.push_back(mon);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int l, input int h, output int c);
        tick();
        bus.idat_l   = 8'(l);
        bus.idat_h   = 8'(h);
        bus.iclk_ena = 1'b1;
        bus.iena     = 1'b1;
        c = cyc;
        tick();
        bus.iclk_ena = 1'b0;
        tick();
    endtask

    // Final pair followed immediately by iena low on the next cycle.
    task automatic send_last(input int l, input int h, output int c, output int cf);
        tick();
        bus.idat_l   = 8'(l);
        bus.idat_h   = 8'(h);
        bus.iclk_ena = 1'b1;
        bus.iena     = 1'b1;
        c = cyc;
        tick();
        bus.iclk_ena = 1'b0;
        bus.iena     = 1'b0;
        cf = cyc;
    endtask

    task automatic stop(output int c);
        tick();
        bus.iena     = 1'b0;
        bus.iclk_ena = 1'b0;
        c = cyc;
    endtask

    task automatic wait_until(input int k);
        do @(negedge clk); while (cyc < k);
    endtask

    task automatic expect_pulse(input string tag, input int a, input int d, input int idx,
                                input logic last, input int at);
        pulse_t p;
        chk({tag, ".present"}, {31'd0, q.size() > 0}, 1);
        if (q.size() > 0) begin
            p = q.pop_front();
            chk({tag, ".a"}, p.a, a);
            chk({tag, ".d"}, p.d, d);
            chk({tag, ".idx"}, p.idx, idx);
            chk({tag, ".last"}, {31'd0, p.last}, {31'd0, last});
            chk({tag, ".oena"}, {31'd0, p.ena}, 1);
            chk({tag, ".cycle"}, p.at, at);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".oclk_ena"}, {31'd0, bus.oclk_ena}, 0);
        chk({tag, ".oena"}, {31'd0, bus.oena}, 0);
        chk({tag, ".oapr"}, bus.oapr, 0);
        chk({tag, ".odet"}, bus.odet, 0);
    endtask

    initial begin
        int c0, c1, c2, cf, cx;
        int cs[10];
        bus.iclk_ena = 1'b0;
        bus.iena     = 1'b0;
        bus.idat_l   = '0;
        bus.idat_h   = '0;
        #3 rst_n = 1'b0;
        tick();
        tick();
        chk_quiet("reset");
        chk("reset.oidx", {29'd0, bus.oidx}, 0);
        chk("reset.olast", {31'd0, bus.olast}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();

        // Two-pair frame.
        send(10, 14, c0);
        send(20, 30, c1);
        stop(cf);
        wait_until(cf + 3);
        expect_pulse("t1p0", 10, -1, 0, 1'b0, c1 + 2);
        expect_pulse("t1p1", 22, 10, 1, 1'b1, cf + 2);
        chk_quiet("t1.after");
        chk("t1.oidx_held", {29'd0, bus.oidx}, 1);

        // Single-pair frame.
        send(5, 9, c0);
        stop(cf);
        wait_until(cf + 3);
        expect_pulse("t2", 7, 4, 0, 1'b1, cf + 2);

        // Negative floor, flush on the cycle right after the last accept.
        send(-3, -8, c0);
        send_last(-4, 0, c1, cf);
        wait_until(cf + 3);
        expect_pulse("t3p0", -5, -4, 0, 1'b0, c1 + 2);
        expect_pulse("t3p1", -4, 4, 1, 1'b1, cf + 2);
        chk_quiet("t3.after");

        // Extremes.
        send(-128, 127, c0);
        stop(cf);
        wait_until(cf + 3);
        expect_pulse("t4a", 0, 255, 0, 1'b1, cf + 2);
        send(127, -128, c0);
        stop(cf);
        wait_until(cf + 3);
        expect_pulse("t4b", 0, -255, 0, 1'b1, cf + 2);

        // Reset mid-frame while a pulse is on the outputs.
        send(1, 2, c0);
        send(3, 4, c1);
        send(5, 6, c2);
        chk("t5.pre_pulse", {31'd0, bus.oclk_ena}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_quiet("t5.async");
        chk("t5.oidx", {29'd0, bus.oidx}, 0);
        chk("t5.olast", {31'd0, bus.olast}, 0);
        q.delete();
        tick();
        tick();
        @(negedge clk) rst_n = 1'b1;
        send(7, 7, cx);
        stop(cf);
        wait_until(cf + 4);
        chk("t5.no_pulses", q.size(), 0);
        send(1, 1, c0);
        send(1, 1, c1);
        stop(cf);
        wait_until(cf + 3);
        expect_pulse("t5p0", 1, 0, 0, 1'b0, c1 + 2);
        expect_pulse("t5p1", 1, 0, 1, 1'b1, cf + 2);

        // Strobes with iena low, then a 10-pair frame exercising the index wrap.
        tick();
        bus.iclk_ena = 1'b1;
        tick();
        bus.iclk_ena = 1'b0;
        repeat (2) tick();
        bus.iclk_ena = 1'b1;
        tick();
        bus.iclk_ena = 1'b0;
        repeat (4) tick();
        chk("t6.ignored", q.size(), 0);
        for (int i = 0; i < 10; i++) send(4, 4, cs[i]);
        stop(cf);
        wait_until(cf + 3);
        chk("t6.count", q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            expect_pulse($sformatf("t6p%0d", i), 4, 0, i % 8, (i == 9),
                         (i < 9) ? cs[i + 1] + 2 : cf + 2);
        end
        chk_quiet("t6.after");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/wvlt_lift53.md
Name: wvlt_lift53

Overview:
- Forward LeGall 5/3 integer lifting stage.
- Consumes even/odd sample pairs (l,h), one pair per read strobe, as delivered by the wavelet post-buffer.
- Produces one approximation/detail coefficient pair per input pair, with symmetric extension at both frame edges.
- Sits directly downstream of the post-buffer and feeds the next decomposition level or the coefficient sink.

Parameters:
- pW_DAT, 16: signed input sample width. Output coefficients are pW_DAT+1.
- pW_CNT, 10: width of the output pair-index counter.

Ports:
- iclk  in  1  system clock (128 MHz).
- irst_n  in  1  asynchronous active-low reset.
- iclk_ena  in  1  pair strobe: one-cycle pulse per pair, at least 3 cycles apart.
- iena  in  1  frame valid; high for the whole frame.
- idat_l  in  pW_DAT  even sample l[n], signed.
- idat_h  in  pW_DAT  odd sample h[n], signed.
- oclk_ena  out  1  output coefficient strobe, one-cycle pulse.
- oena  out  1  output frame valid.
- oapr  out  pW_DAT+1  approximation a[n], signed.
- odet  out  pW_DAT+1  detail d[n], signed.
- oidx  out  pW_CNT  pair index n of the current output.
- olast  out  1  marks the final pair of the frame; valid with oclk_ena.

Behaviour:
- Reset: one clock iclk; reset is asynchronous, active-low on irst_n. Reset clears every register. All outputs are 0; FSM goes to IDLE.
- Accept: a pair is accepted on any cycle with iclk_ena && iena. iclk_ena is ignored while iena is low.
- Math, all signed with floor, i.e. arithmetic shift right:
  - d[n] = h[n] - ((l[n] + l[n+1]) >>> 1)
  - a[n] = l[n] + ((d[n-1] + d[n] + 2) >>> 2)
  - Sums are computed at pW_DAT+3 bits. Results fit in pW_DAT+1 bits; no saturation.
- Edge extension:
  - Leading edge: d[-1] = d[0].
  - Trailing edge: l[N] = l[N-1], so d[N-1] = h[N-1] - l[N-1].
- FSM states:
  - IDLE: on accept, store pair 0 and go to PRIME.
  - PRIME: holds pair 0 only. On accept of pair 1, issue the pair-0 compute with d[-1] = d[0] and go to RUN. If iena is seen low, issue a flush compute of single pair 0 and go to IDLE.
  - RUN: on accept of pair n+1, issue the compute of pair n using stored d[n-1]. If iena is seen low, issue a flush compute of the pending pair with olast=1 and go to IDLE.
- Issue/latency: a compute is issued on the accept cycle t, or on the first cycle t with iena low after a frame.
  - Stage 1 registers d at t+1.
  - Stage 2 registers a at t+2; oclk_ena pulses for one cycle at t+2.
  - oapr/odet/oidx/olast are held between pulses.
- Single-pair frame (N=1): d = h - l, a = l + ((2d + 2) >>> 2), olast=1, oidx=0.
- oena:
  - Rises with the first oclk_ena pulse of a frame.
  - Falls the cycle after the olast pulse.
  - oapr/odet read 0 whenever oclk_ena is low.
- oidx:
  - Resets to 0 at frame start and increments after each output pulse.
  - Wraps modulo 2^pW_CNT with no flag.
- Simultaneous events:
  - iena rising on the flush cycle of the previous frame: the flush has priority. The new frame's first accept can occur no earlier than t+1.
  - An iclk_ena pulse coinciding with iena falling is not accepted.
- Reset mid-frame drops pending pairs; no flush or olast is produced. After release, the block waits for the next iena rising.
- iena low for a whole frame with no accepts: no outputs.

Test Plan:
- pW_DAT=8. Frame l={10,20}, h={14,30} -> two oclk_ena pulses:
  - (a,d,idx,last) = (10,-1,0,0) at 2 cycles after the pair-1 accept.
  - (22,10,1,1) at 2 cycles after iena falls.
  - oena high across both pulses, low the cycle after.
- Single pair l=5, h=9 -> one pulse with a=7, d=4, olast=1, oidx=0.
- Negative floor, l={-3,-4}, h={-8,0} -> (a,d) = (-5,-4) then (-4,4).
- Extremes:
  - l=-128, h=127 -> d=255, a=0.
  - l=127, h=-128 -> d=-255, a=0.
  - No wrap in 9-bit outputs.
- Reset mid-frame: assert irst_n=0 after 3 accepts.
  - All outputs 0 immediately (asynchronous).
  - No further pulses after release until the next frame.
  - Next frame l={1,1}, h={1,1} -> (a,d) = (1,0),(1,0), oidx restarts at 0.
- Long frame: pW_CNT=3, 10 pairs of constant l=h=4.
  - Every output is a=4, d=0.
  - oidx sequence 0..7,0,1; olast only on the 10th pulse.
  - iclk_ena pulses while iena is low are ignored.
